dsp_spi_frame_slave: RTL

Parametrised DSP-to-FPGA SPI slave that receives a command word and a data word in each frame and returns a selected read-back channel to the DSP. It supersedes the fixed 16+16-bit, two-source link with the following additions:
- configurable word widths and channel count;
- back-to-back frames;
- a toggle-based frame-done indication for safe capture in the system clock domain;
- optional parity protection.

All logic runs on `DSP_SPI_CLK`.

---
 rtl/dsp_spi_pkg.sv | 24 ++
 rtl/dsp_spi_tx_shifter.sv | 69 ++++++
 rtl/dsp_spi_frame_slave.sv | 107 ++++++++++
 3 files changed

// File: rtl/dsp_spi_pkg.sv
// rtl/dsp_spi_pkg.sv - widths, frame length and phase type for the DSP SPI slave; SPI_PARITY_EN adds a parity bit
package dsp_spi_pkg;

    localparam int DEF_CMD_W  = 16;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_N_CH   = 4;

`ifdef SPI_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif

    typedef enum logic [1:0] {
        PH_CMD,
        PH_DATA,
        PH_PAR
    } phase_t;

    function automatic int frame_len(input int cmd_w, input int data_w);
        return cmd_w + data_w + PAR_W;
    endfunction

endpackage

// File: rtl/dsp_spi_tx_shifter.sv
// rtl/dsp_spi_tx_shifter.sv - read-back channel mux, MISO shifter and read-back parity (SPI_PARITY_EN)
module dsp_spi_tx_shifter
    import dsp_spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH,
    parameter int CH_W   = $clog2(N_CH)
) (
    input  logic                     DSP_SPI_CLK,
    input  logic                     n_rst,
    input  logic                     DSP_SPI_EN,
    input  logic                     sel_load,
    input  logic [CH_W-1:0]          ch_sel,
    input  phase_t                   phase,
    input  logic [N_CH*DATA_W-1:0]   rd_data,
    output logic                     DSP_SPI_FDOUT
);

    logic [DATA_W-1:0] ch_word;
    logic [DATA_W-1:0] tx_shift;
`ifdef SPI_PARITY_EN
    logic              rb_par;
`endif

    // Indices beyond the populated channels read back as zero.
    always_comb begin
        ch_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (int'(ch_sel) == c) begin
                ch_word = rd_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge DSP_SPI_CLK or negedge n_rst or posedge DSP_SPI_EN) begin
        if (!n_rst) begin
            tx_shift      <= '0;
            DSP_SPI_FDOUT <= 1'b0;
`ifdef SPI_PARITY_EN
            rb_par        <= 1'b0;
`endif
        end else if (DSP_SPI_EN) begin
            tx_shift      <= '0;
            DSP_SPI_FDOUT <= 1'b0;
`ifdef SPI_PARITY_EN
            rb_par        <= 1'b0;
`endif
        end else begin
            if (sel_load) begin
                tx_shift <= ch_word;
            end else if (phase == PH_DATA) begin
                tx_shift <= tx_shift << 1;
            end
            DSP_SPI_FDOUT <= 1'b0;
            if (phase == PH_DATA) begin
                DSP_SPI_FDOUT <= tx_shift[DATA_W-1];
            end
`ifdef SPI_PARITY_EN
            if (phase == PH_PAR) begin
                DSP_SPI_FDOUT <= rb_par;
            end
            if (sel_load) begin
                rb_par <= ^ch_word;
            end
`endif
        end
    end

endmodule

// File: rtl/dsp_spi_frame_slave.sv
// rtl/dsp_spi_frame_slave.sv - DSP SPI frame slave: command+data receive, read-back, toggle commit; SPI_PARITY_EN adds parity and err_cnt
module dsp_spi_frame_slave
    import dsp_spi_pkg::*;
#(
    parameter int CMD_W  = DEF_CMD_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int N_CH   = DEF_N_CH
) (
    input  logic                     n_rst,
    input  logic                     DSP_SPI_CLK,
    input  logic                     DSP_SPI_EN,
    input  logic                     DSP_SPI_DFIN,
    input  logic [N_CH*DATA_W-1:0]   rd_data,
    output logic                     DSP_SPI_FDOUT,
    output logic [CMD_W-1:0]         cmd_out,
    output logic [DATA_W-1:0]        data_out,
`ifdef SPI_PARITY_EN
    output logic [7:0]               err_cnt,
`endif
    output logic                     frame_tgl
);

    localparam int CH_W      = $clog2(N_CH);
    localparam int FRAME_LEN = frame_len(CMD_W, DATA_W);
    localparam int BCNT_W    = $clog2(FRAME_LEN);
    localparam logic [BCNT_W-1:0] SEL_CNT  = BCNT_W'(CMD_W - 1);
    localparam logic [BCNT_W-1:0] LAST_CNT = BCNT_W'(FRAME_LEN - 1);

    logic [BCNT_W-1:0]    bcnt;
    logic [FRAME_LEN-2:0] rx_shift;
    logic [FRAME_LEN-1:0] rx_next;
    logic                 frame_end;
    logic                 parity_ok;
    phase_t               phase;

    // rx_next is the frame as it stands after the current edge, so the last
    // bit is already included when selecting or committing on that edge.
    assign rx_next   = {rx_shift, DSP_SPI_DFIN};
    assign frame_end = (bcnt == LAST_CNT);

`ifdef SPI_PARITY_EN
    assign parity_ok = ~^rx_next;
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        phase = PH_PAR;
        if (int'(bcnt) < CMD_W) begin
            phase = PH_CMD;
        end else if (int'(bcnt) < CMD_W + DATA_W) begin
            phase = PH_DATA;
        end
    end

    always_ff @(posedge DSP_SPI_CLK or negedge n_rst or posedge DSP_SPI_EN) begin
        if (!n_rst) begin
            bcnt     <= '0;
            rx_shift <= '0;
        end else if (DSP_SPI_EN) begin
            bcnt     <= '0;
            rx_shift <= '0;
        end else begin
            rx_shift <= rx_next[FRAME_LEN-2:0];
            bcnt     <= frame_end ? '0 : bcnt + BCNT_W'(1);
        end
    end

    // Committed words survive chip-select deassertion; only n_rst clears them.
    always_ff @(posedge DSP_SPI_CLK or negedge n_rst) begin
        if (!n_rst) begin
            cmd_out   <= '0;
            data_out  <= '0;
            frame_tgl <= 1'b0;
`ifdef SPI_PARITY_EN
            err_cnt   <= 8'd0;
`endif
        end else if (!DSP_SPI_EN && frame_end) begin
            if (parity_ok) begin
                cmd_out   <= rx_next[FRAME_LEN-1 -: CMD_W];
                data_out  <= rx_next[FRAME_LEN-1-CMD_W -: DATA_W];
                frame_tgl <= ~frame_tgl;
            end
`ifdef SPI_PARITY_EN
            else if (err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
`endif
        end
    end

    dsp_spi_tx_shifter #(
        .DATA_W (DATA_W),
        .N_CH   (N_CH),
        .CH_W   (CH_W)
    ) u_tx (
        .DSP_SPI_CLK   (DSP_SPI_CLK),
        .n_rst         (n_rst),
        .DSP_SPI_EN    (DSP_SPI_EN),
        .sel_load      (bcnt == SEL_CNT),
        .ch_sel        (rx_next[CH_W-1:0]),
        .phase         (phase),
        .rd_data       (rd_data),
        .DSP_SPI_FDOUT (DSP_SPI_FDOUT)
    );

endmodule
